// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB slave memory.
// Optional byte-strobe support is enabled by defining APB_SLAVE_WSTRB_EN.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_slv_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  // Number of byte lanes in a data word.
  function automatic int unsigned lane_cnt(input int unsigned dw);
    return dw / 8;
  endfunction

  // Byte-address to word-index shift amount.
  function automatic int unsigned addr_shift(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus signal bundle between master and the slave memory.
// Carries a byte strobe only when APB_SLAVE_WSTRB_EN is defined.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

interface apb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = `APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `APB_DATA_WIDTH
);
  logic                  sel;
  logic                  enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef APB_SLAVE_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] strb;
`endif
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  slave_error;

  modport master (
`ifdef APB_SLAVE_WSTRB_EN
    output strb,
`endif
    output sel, enable, addr, write, wdata,
    input  rdata, ready, slave_error
  );

  modport slave (
`ifdef APB_SLAVE_WSTRB_EN
    input  strb,
`endif
    input  sel, enable, addr, write, wdata,
    output rdata, ready, slave_error
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// Word storage with async clear, byte-enabled write port and combinational read port.
module apb_slave_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [IDX_W-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  localparam int unsigned LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Clear all words on reset; update enabled byte lanes on write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave terminating transfers into a small word-addressed memory with
// programmable wait states and error response for unmapped/misaligned access.
// Define APB_SLAVE_WSTRB_EN to honour per-byte write strobes.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = `APB_ADDR_WIDTH,
  parameter int unsigned          DATA_WIDTH  = `APB_DATA_WIDTH,
  parameter int unsigned          DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned          WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rstn,
  apb_slave_mem_if.slave bus
);
  localparam int unsigned LANES = lane_cnt(DATA_WIDTH);
  localparam int unsigned SHIFT = addr_shift(DATA_WIDTH);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_slv_state_t          r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [LANES-1:0]        w_be;
  logic                    w_latch;
  logic                    w_we;
  logic                    w_setup;
  logic [ADDR_WIDTH-1:0]   w_dec_addr;
  logic                    w_dec_write;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic [ADDR_WIDTH-1:0]   w_word;
  logic                    w_err;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_rd_word;

`ifdef APB_SLAVE_WSTRB_EN
  logic [LANES-1:0]        r_strb;
  assign w_be = r_strb;
`else
  assign w_be = '1;
`endif

  assign w_setup = bus.sel && !bus.enable;

  // Decode the live address in IDLE (zero-wait completion) and the latched one afterwards.
  assign w_dec_addr  = (r_state == IDLE) ? bus.addr  : r_addr;
  assign w_dec_write = (r_state == IDLE) ? bus.write : r_write;
  assign w_offset    = w_dec_addr - BASE_ADDR;
  assign w_word      = w_offset >> SHIFT;
  assign w_err       = (w_dec_addr < BASE_ADDR)
                    || (w_word >= ADDR_WIDTH'(DEPTH))
                    || ((w_dec_addr & ADDR_WIDTH'(LANES - 1)) != '0);
  assign w_idx       = w_word[IDX_W-1:0];

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_be    (w_be),
    .i_raddr (w_idx),
    .o_rdata (w_rd_word)
  );

  // State, counter, output and request-latch registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
`ifdef APB_SLAVE_WSTRB_EN
      r_strb  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_latch) begin
        r_addr  <= bus.addr;
        r_write <= bus.write;
        r_wdata <= bus.wdata;
`ifdef APB_SLAVE_WSTRB_EN
        r_strb  <= bus.strb;
`endif
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_setup) w_state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
      end
      WAIT: begin
        if (!bus.sel)                          w_state_nxt = IDLE;
        else if (bus.enable && (r_cnt == '0))  w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter, latch and write strobe.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_ready_nxt = 1'b1;
            w_err_nxt   = w_err;
            w_rdata_nxt = (!w_dec_write && !w_err) ? w_rd_word : '0;
          end else begin
            w_cnt_nxt = WAIT_CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!bus.sel) begin
          w_cnt_nxt = '0;
        end else if (bus.enable) begin
          if (r_cnt == '0) begin
            w_ready_nxt = 1'b1;
            w_err_nxt   = w_err;
            w_rdata_nxt = (!w_dec_write && !w_err) ? w_rd_word : '0;
          end else begin
            w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
          end
        end
      end
      DONE: begin
        // A deselect here aborts the transfer, so the write is dropped.
        w_we      = bus.sel && w_dec_write && !w_err;
        w_cnt_nxt = '0;
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  assign bus.ready       = r_ready;
  assign bus.slave_error = r_err;
  assign bus.rdata       = r_rdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem: one 2-wait-state and one
// zero-wait-state instance, checked against an array memory model.
module tb_apb_slave_mem;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int          W0     = 2;
  localparam int          W1     = 0;
  localparam int          MAXLAT = 20;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        sel, enable, write;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  int          dsel;

  logic [31:0] mdl [2][DEPTH];
  int          n_pass;
  int          n_checks;

  always #5 clk = ~clk;

  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if1 ();

  assign u_if0.sel    = sel && (dsel == 0);
  assign u_if1.sel    = sel && (dsel == 1);
  assign u_if0.enable = enable;
  assign u_if1.enable = enable;
  assign u_if0.addr   = addr;
  assign u_if1.addr   = addr;
  assign u_if0.write  = write;
  assign u_if1.write  = write;
  assign u_if0.wdata  = wdata;
  assign u_if1.wdata  = wdata;
`ifdef APB_SLAVE_WSTRB_EN
  assign u_if0.strb   = strb;
  assign u_if1.strb   = strb;
`endif

  apb_slave_mem #(.WAIT_CYCLES(W0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(u_if0));
  apb_slave_mem #(.WAIT_CYCLES(W1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(u_if1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic cur_ready();
    return (dsel == 0) ? u_if0.ready : u_if1.ready;
  endfunction
  function automatic logic cur_err();
    return (dsel == 0) ? u_if0.slave_error : u_if1.slave_error;
  endfunction
  function automatic logic [31:0] cur_rdata();
    return (dsel == 0) ? u_if0.rdata : u_if1.rdata;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // Unmapped (past DEPTH words from base 0) or not word aligned.
  function automatic bit exp_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [3:0] eff_strb(input logic [3:0] st);
`ifdef APB_SLAVE_WSTRB_EN
    return st;
`else
    return 4'hF;
`endif
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [3:0]  m;
    logic [31:0] w;
    m = eff_strb(st);
    w = mdl[d][a / 4];
    for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    mdl[d][a / 4] = w;
  endtask

  task automatic mdl_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'h0;
  endtask

  // One APB transfer, entered and left just after a falling edge.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input int abort_at, input bit rst_in_done);
    int          k;
    bit          seen, any, err;
    logic [31:0] exp_rd;
    err    = exp_err(a);
    exp_rd = 32'h0;
    if (!wr && !err) exp_rd = mdl[d][a / 4];
    dsel = d; sel = 1'b1; enable = 1'b0; addr = a; write = wr; wdata = wd; strb = st;
    seen = 1'b0;
    k    = 0;
    while (!seen && k <= MAXLAT) begin
      @(negedge clk);
      enable = 1'b1;
      if (cur_ready()) seen = 1'b1;
      else if (abort_at >= 0 && k == abort_at) break;
      else k++;
    end
    if (abort_at >= 0) begin
      any = seen;
      sel = 1'b0; enable = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (cur_ready()) any = 1'b1;
      end
      check_eq("abort_no_ready", 32'(any), 32'h0);
      return;
    end
    check_eq("latency", seen ? 32'(k) : 32'(MAXLAT + 1), 32'(lat(d)));
    if (seen) begin
      check_eq("slverr", 32'(cur_err()), 32'(err));
      check_eq("rdata", cur_rdata(), exp_rd);
      if (rst_in_done) begin
        rstn = 1'b0;
        #1;
        check_eq("rst_ready", 32'(cur_ready()), 32'h0);
        check_eq("rst_slverr", 32'(cur_err()), 32'h0);
        check_eq("rst_rdata", cur_rdata(), 32'h0);
        mdl_clear();
        sel = 1'b0; enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      @(negedge clk);
      check_eq("ready_pulse", 32'(cur_ready()), 32'h0);
      if (wr && !err) mdl_write(d, a, wd, st);
    end
    sel = 1'b0; enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d, r, ab;
    bit          wr;
    logic [31:0] a;
    n_pass = 0; n_checks = 0;
    sel = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0; strb = 4'hF; dsel = 0;
    mdl_clear();

    // Reset held for 3 cycles, outputs idle.
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", 32'(u_if0.ready), 32'h0);
    check_eq("reset_slverr", 32'(u_if0.slave_error), 32'h0);
    check_eq("reset_rdata", u_if0.rdata, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, -1, 1'b0);

    // Write then read back, neighbours untouched.
    apb_xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'hC, 32'h0, 4'hF, -1, 1'b0);

    // Zero-wait instance: back-to-back writes, then readback.
    apb_xfer(1, 1'b1, 32'h0, 32'h0102_0304, 4'hF, -1, 1'b0);
    apb_xfer(1, 1'b1, 32'h4, 32'h5566_7788, 4'hF, -1, 1'b0);
    apb_xfer(1, 1'b1, 32'h8, 32'h99AA_BBCC, 4'hF, -1, 1'b0);
    for (int i = 0; i < 3; i++) apb_xfer(1, 1'b0, 32'(i * 4), 32'h0, 4'hF, -1, 1'b0);

    // Error responses leave memory alone.
    apb_xfer(0, 1'b1, 32'h40, 32'h1234, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h2, 32'h0, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, -1, 1'b0);

    // Abort after one wait cycle: no ready, no write.
    apb_xfer(0, 1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 1, 1'b0);
    apb_xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, -1, 1'b0);

`ifdef APB_SLAVE_WSTRB_EN
    apb_xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b1, 32'h10, 32'h0000_0000, 4'b0000, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, -1, 1'b0);
`endif

    // Random traffic across both instances.
    for (int i = 0; i < 150; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'(64 + $urandom_range(0, 15) * 4);
      else             a = $urandom | 32'h100;
      ab = -1;
      if (d == 0 && $urandom_range(0, 9) == 0) ab = int'($urandom_range(0, W0 - 1));
      apb_xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), ab, 1'b0);
    end

    // Reset while ready is high on a read of a non-zero word.
    apb_xfer(0, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, -1, 1'b0);
    apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, -1, 1'b1);
    apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, -1, 1'b0);
    apb_xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
